// File: rtl/pc_redirect_ctrl.sv
// Fetch redirect sequencer: arbitrates trap/mispredict/decode redirects, waits for fetch idle,
// issues one alter pulse, then flushes/stalls for DRAIN_CYCLES. Define PC_REDIRECT_PERF_EN for per-source counters.
module pc_redirect_ctrl #(
    parameter int unsigned DRAIN_CYCLES = 2,
    parameter int unsigned CNT_WIDTH    = 32,
    parameter int unsigned PC_WIDTH     = 32
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_trap_req,
    input  logic [PC_WIDTH-1:0]  i_trap_pc,
    input  logic                 i_mispred_req,
    input  logic [PC_WIDTH-1:0]  i_mispred_pc,
    input  logic                 i_decode_req,
    input  logic [PC_WIDTH-1:0]  i_decode_pc,
    input  logic                 i_fetch_idle,
    input  logic                 i_stall_in,
    output logic                 o_alter,
    output logic [PC_WIDTH-1:0]  o_pc,
    output logic                 o_stall,
    output logic                 o_flush_fetch,
    output logic                 o_flush_decode,
    output logic                 o_busy,
    output logic [CNT_WIDTH-1:0] o_cnt_trap,
    output logic [CNT_WIDTH-1:0] o_cnt_mispred,
    output logic [CNT_WIDTH-1:0] o_cnt_decode
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HOLD,
        ST_ISSUE,
        ST_DRAIN
    } state_t;

    localparam logic [1:0] SRC_TRAP    = 2'd0;
    localparam logic [1:0] SRC_MISPRED = 2'd1;
    localparam logic [1:0] SRC_DECODE  = 2'd2;
    localparam logic [3:0] DRAIN_LOAD  = 4'(DRAIN_CYCLES > 0 ? DRAIN_CYCLES - 1 : 0);

    state_t              state;
    logic [PC_WIDTH-1:0] cap_pc;
    logic [1:0]          cap_src;
    logic [3:0]          drain_cnt;

    logic                any_req;
    logic [1:0]          win_src;
    logic [PC_WIDTH-1:0] win_pc;
    logic                late_req;
    logic [1:0]          late_src;
    logic [PC_WIDTH-1:0] late_pc;
    logic                accept;
    logic [1:0]          acc_src;
    logic [PC_WIDTH-1:0] acc_pc;

    always_comb begin
        any_req  = i_trap_req | i_mispred_req | i_decode_req;
        win_src  = SRC_DECODE;
        win_pc   = i_decode_pc;
        if (i_trap_req) begin
            win_src = SRC_TRAP;
            win_pc  = i_trap_pc;
        end else if (i_mispred_req) begin
            win_src = SRC_MISPRED;
            win_pc  = i_mispred_pc;
        end

        // After an issue, decode requests are wrong-path, so only trap/mispred compete.
        late_req = i_trap_req | i_mispred_req;
        late_src = i_trap_req ? SRC_TRAP : SRC_MISPRED;
        late_pc  = i_trap_req ? i_trap_pc : i_mispred_pc;

        accept   = 1'b0;
        acc_src  = win_src;
        acc_pc   = win_pc;
        case (state)
            ST_IDLE:  accept = any_req;
            ST_HOLD:  accept = any_req && (win_src < cap_src);
            ST_ISSUE,
            ST_DRAIN: begin
                accept  = late_req && (late_src <= cap_src);
                acc_src = late_src;
                acc_pc  = late_pc;
            end
            default:  accept = 1'b0;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= ST_IDLE;
            cap_pc    <= '0;
            cap_src   <= '0;
            drain_cnt <= '0;
        end else if (accept) begin
            cap_pc  <= acc_pc;
            cap_src <= acc_src;
            state   <= i_fetch_idle ? ST_ISSUE : ST_HOLD;
        end else begin
            case (state)
                ST_HOLD: begin
                    if (i_fetch_idle) state <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    drain_cnt <= DRAIN_LOAD;
                    state     <= (DRAIN_CYCLES == 0) ? ST_IDLE : ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (drain_cnt == '0) state <= ST_IDLE;
                    else                 drain_cnt <= drain_cnt - 4'd1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign o_alter        = (state == ST_ISSUE);
    assign o_pc           = o_alter ? cap_pc : '0;
    assign o_flush_fetch  = (state == ST_ISSUE) || (state == ST_DRAIN);
    assign o_flush_decode = o_flush_fetch && (cap_src != SRC_DECODE);
    assign o_busy         = (state != ST_IDLE);
    assign o_stall        = i_stall_in | o_busy;

`ifdef PC_REDIRECT_PERF_EN
    logic [CNT_WIDTH-1:0] cnt_trap;
    logic [CNT_WIDTH-1:0] cnt_mispred;
    logic [CNT_WIDTH-1:0] cnt_decode;

    // Saturating per-source counts of issued redirects.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_trap    <= '0;
            cnt_mispred <= '0;
            cnt_decode  <= '0;
        end else if (state == ST_ISSUE) begin
            case (cap_src)
                SRC_TRAP:    if (cnt_trap    != '1) cnt_trap    <= cnt_trap    + 1'b1;
                SRC_MISPRED: if (cnt_mispred != '1) cnt_mispred <= cnt_mispred + 1'b1;
                SRC_DECODE:  if (cnt_decode  != '1) cnt_decode  <= cnt_decode  + 1'b1;
                default:     ;
            endcase
        end
    end

    assign o_cnt_trap    = cnt_trap;
    assign o_cnt_mispred = cnt_mispred;
    assign o_cnt_decode  = cnt_decode;
`else
    assign o_cnt_trap    = '0;
    assign o_cnt_mispred = '0;
    assign o_cnt_decode  = '0;
`endif

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Table-driven scoreboard bench for pc_redirect_ctrl: DRAIN_CYCLES=2 instance plus a
// DRAIN_CYCLES=0, CNT_WIDTH=2 instance for back-to-back issue and counter saturation.
module tb_pc_redirect_ctrl;

`ifdef PC_REDIRECT_PERF_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif

    typedef struct {
        logic        rst;
        logic        trap;
        logic [31:0] tpc;
        logic        mis;
        logic [31:0] mpc;
        logic        dec;
        logic [31:0] dpc;
        logic        idle;
        logic        stin;
        logic        alter;
        logic [31:0] pc;
        logic        stall;
        logic        ff;
        logic        fd;
        logic        busy;
        int          ct;
        int          cm;
        int          cd;
    } vec_t;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_trap_req = 1'b0, i_mispred_req = 1'b0, i_decode_req = 1'b0;
    logic [31:0] i_trap_pc = '0, i_mispred_pc = '0, i_decode_pc = '0;
    logic        i_fetch_idle = 1'b0, i_stall_in = 1'b0;

    logic        alter, stall, ff, fd, busy;
    logic [31:0] pc, cnt_t, cnt_m, cnt_d;
    logic        alter0, stall0, ff0, fd0, busy0;
    logic [31:0] pc0;
    logic [1:0]  cnt_t0, cnt_m0, cnt_d0;

    int checks = 0;
    int errors = 0;
    vec_t sb[$];
    vec_t tbl[39];

    always #5 i_clk = ~i_clk;

    pc_redirect_ctrl #(.DRAIN_CYCLES(2), .CNT_WIDTH(32)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_trap_req(i_trap_req), .i_trap_pc(i_trap_pc),
        .i_mispred_req(i_mispred_req), .i_mispred_pc(i_mispred_pc),
        .i_decode_req(i_decode_req), .i_decode_pc(i_decode_pc),
        .i_fetch_idle(i_fetch_idle), .i_stall_in(i_stall_in),
        .o_alter(alter), .o_pc(pc), .o_stall(stall),
        .o_flush_fetch(ff), .o_flush_decode(fd), .o_busy(busy),
        .o_cnt_trap(cnt_t), .o_cnt_mispred(cnt_m), .o_cnt_decode(cnt_d)
    );

    pc_redirect_ctrl #(.DRAIN_CYCLES(0), .CNT_WIDTH(2)) dut0 (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_trap_req(i_trap_req), .i_trap_pc(i_trap_pc),
        .i_mispred_req(i_mispred_req), .i_mispred_pc(i_mispred_pc),
        .i_decode_req(i_decode_req), .i_decode_pc(i_decode_pc),
        .i_fetch_idle(i_fetch_idle), .i_stall_in(i_stall_in),
        .o_alter(alter0), .o_pc(pc0), .o_stall(stall0),
        .o_flush_fetch(ff0), .o_flush_decode(fd0), .o_busy(busy0),
        .o_cnt_trap(cnt_t0), .o_cnt_mispred(cnt_m0), .o_cnt_decode(cnt_d0)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one cycle of stimulus, queue its expectation, compare after the edge.
    task automatic apply(input vec_t v, input bit sel, input int idx);
        vec_t e;
        string tag;
        i_rst         = v.rst;
        i_trap_req    = v.trap;
        i_trap_pc     = v.tpc;
        i_mispred_req = v.mis;
        i_mispred_pc  = v.mpc;
        i_decode_req  = v.dec;
        i_decode_pc   = v.dpc;
        i_fetch_idle  = v.idle;
        i_stall_in    = v.stin;
        sb.push_back(v);
        @(posedge i_clk);
        #1;
        e   = sb.pop_front();
        tag = $sformatf("%s%0d", sel ? "d0_row" : "row", idx);
        if (!sel) begin
            chk({tag, " alter"}, {31'd0, alter}, {31'd0, e.alter});
            chk({tag, " pc"}, pc, e.pc);
            chk({tag, " stall"}, {31'd0, stall}, {31'd0, e.stall});
            chk({tag, " flush_fetch"}, {31'd0, ff}, {31'd0, e.ff});
            chk({tag, " flush_decode"}, {31'd0, fd}, {31'd0, e.fd});
            chk({tag, " busy"}, {31'd0, busy}, {31'd0, e.busy});
            chk({tag, " cnt_trap"}, cnt_t, 32'(e.ct * P));
            chk({tag, " cnt_mispred"}, cnt_m, 32'(e.cm * P));
            chk({tag, " cnt_decode"}, cnt_d, 32'(e.cd * P));
        end else begin
            chk({tag, " alter"}, {31'd0, alter0}, {31'd0, e.alter});
            chk({tag, " pc"}, pc0, e.pc);
            chk({tag, " stall"}, {31'd0, stall0}, {31'd0, e.stall});
            chk({tag, " flush_fetch"}, {31'd0, ff0}, {31'd0, e.ff});
            chk({tag, " flush_decode"}, {31'd0, fd0}, {31'd0, e.fd});
            chk({tag, " busy"}, {31'd0, busy0}, {31'd0, e.busy});
            chk({tag, " cnt_decode"}, {30'd0, cnt_d0}, 32'(e.cd * P));
            chk({tag, " cnt_trap"}, {30'd0, cnt_t0}, 32'd0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t v;
        //        rst trp tpc     mis mpc      dec dpc      idl stn  alt pc       stl ff fd bsy ct cm cd
        tbl = '{
            '{1, 0, 0,      0, 0,       0, 0,       1, 0,   0, 0,       0, 0, 0, 0,  0, 0, 0},
            '{1, 0, 0,      0, 0,       0, 0,       1, 1,   0, 0,       1, 0, 0, 0,  0, 0, 0},
            '{0, 0, 0,      1, 'h1000,  0, 0,       1, 0,   1, 'h1000,  1, 1, 1, 1,  0, 0, 0},
            '{0, 0, 0,      0, 0,       0, 0,       1, 0,   0, 0,       1, 1, 1, 1,  0, 1, 0},
            '{0, 0, 0,      0, 0,       0, 0,       1, 0,   0, 0,       1, 1, 1, 1,  0, 1, 0},
            '{0, 0, 0,      0, 0,       0, 0,       1, 0,   0, 0,       0, 0, 0, 0,  0, 1, 0},
            '{0, 0, 0,      0, 0,       1, 'h2000,  0, 0,   0, 0,       1, 0, 0, 1,  0, 1, 0},
            '{0, 0, 0,      0, 0,       1, 'h2000,  0, 0,   0, 0,       1, 0, 0, 1,  0, 1, 0},
            '{0, 1, 'h80,   0, 0,       1, 'h2000,  0, 0,   0, 0,       1, 0, 0, 1,  0, 1, 0},
            '{0, 0, 0,      0, 0,       1, 'h2000,  0, 0,   0, 0,       1, 0, 0, 1,  0, 1, 0},
            '{0, 0, 0,      0, 0,       0, 0,       1, 0,   1, 'h80,    1, 1, 1, 1,  0, 1, 0},
            '{0, 0, 0,      0, 0,       0, 0,       1, 0,   0, 0,       1, 1, 1, 1,  1, 1, 0},
            '{0, 0, 0,      0, 0,       0, 0,       1, 0,   0, 0,       1, 1, 1, 1,  1, 1, 0},
            '{0, 0, 0,      0, 0,       0, 0,       1, 0,   0, 0,       0, 0, 0, 0,  1, 1, 0},
            '{0, 0, 0,      0, 0,       0, 0,       1, 1,   0, 0,       1, 0, 0, 0,  1, 1, 0},
            '{1, 0, 0,      0, 0,       0, 0,       1, 0,   0, 0,       0, 0, 0, 0,  0, 0, 0},
            '{0, 1, 'h300,  1, 'h400,   1, 'h500,   1, 0,   1, 'h300,   1, 1, 1, 1,  0, 0, 0},
            '{0, 0, 0,      0, 0,       0, 0,       1, 0,   0, 0,       1, 1, 1, 1,  1, 0, 0},
            '{0, 0, 0,      0, 0,       0, 0,       1, 0,   0, 0,       1, 1, 1, 1,  1, 0, 0},
            '{0, 0, 0,      0, 0,       0, 0,       1, 0,   0, 0,       0, 0, 0, 0,  1, 0, 0},
            '{0, 0, 0,      1, 'h1000,  0, 0,       1, 0,   1, 'h1000,  1, 1, 1, 1,  1, 0, 0},
            '{0, 0, 0,      0, 0,       0, 0,       1, 0,   0, 0,       1, 1, 1, 1,  1, 1, 0},
            '{0, 1, 'h100,  0, 0,       1, 'h600,   1, 0,   1, 'h100,   1, 1, 1, 1,  1, 1, 0},
            '{0, 0, 0,      1, 'h700,   0, 0,       1, 0,   0, 0,       1, 1, 1, 1,  2, 1, 0},
            '{0, 0, 0,      0, 0,       0, 0,       1, 0,   0, 0,       1, 1, 1, 1,  2, 1, 0},
            '{0, 0, 0,      0, 0,       0, 0,       1, 0,   0, 0,       0, 0, 0, 0,  2, 1, 0},
            '{0, 0, 0,      0, 0,       0, 0,       1, 0,   0, 0,       0, 0, 0, 0,  2, 1, 0},
            '{0, 0, 0,      0, 0,       1, 'h2000,  1, 0,   1, 'h2000,  1, 1, 0, 1,  2, 1, 0},
            '{0, 0, 0,      0, 0,       0, 0,       1, 0,   0, 0,       1, 1, 0, 1,  2, 1, 1},
            '{0, 0, 0,      1, 'hA00,   0, 0,       0, 0,   0, 0,       1, 0, 0, 1,  2, 1, 1},
            '{0, 0, 0,      0, 0,       0, 0,       0, 0,   0, 0,       1, 0, 0, 1,  2, 1, 1},
            '{0, 0, 0,      0, 0,       0, 0,       1, 0,   1, 'hA00,   1, 1, 1, 1,  2, 1, 1},
            '{0, 0, 0,      0, 0,       0, 0,       1, 0,   0, 0,       1, 1, 1, 1,  2, 2, 1},
            '{0, 0, 0,      0, 0,       0, 0,       1, 0,   0, 0,       1, 1, 1, 1,  2, 2, 1},
            '{0, 0, 0,      0, 0,       0, 0,       1, 0,   0, 0,       0, 0, 0, 0,  2, 2, 1},
            '{0, 0, 0,      1, 'h900,   0, 0,       0, 0,   0, 0,       1, 0, 0, 1,  2, 2, 1},
            '{1, 0, 0,      1, 'h900,   0, 0,       1, 0,   0, 0,       0, 0, 0, 0,  0, 0, 0},
            '{0, 0, 0,      0, 0,       0, 0,       1, 0,   0, 0,       0, 0, 0, 0,  0, 0, 0},
            '{0, 0, 0,      0, 0,       0, 0,       1, 0,   0, 0,       0, 0, 0, 0,  0, 0, 0}
        };

        for (int i = 0; i < 39; i++) apply(tbl[i], 1'b0, i);

        // Zero-drain instance: held decode request issues every other cycle; 2-bit count saturates at 3.
        v = '{1, 0, 0, 0, 0, 0, 0, 1, 0,  0, 0, 0, 0, 0, 0,  0, 0, 0};
        apply(v, 1'b1, 0);
        for (int k = 0; k < 10; k++) begin
            v       = '{0, 0, 0, 0, 0, 1, 'h40, 1, 0,  0, 0, 0, 0, 0, 0,  0, 0, 0};
            v.alter = ((k % 2) == 0);
            v.pc    = v.alter ? 32'h40 : 32'h0;
            v.stall = v.alter;
            v.ff    = v.alter;
            v.busy  = v.alter;
            v.cd    = ((k + 1) / 2 > 3) ? 3 : (k + 1) / 2;
            apply(v, 1'b1, k + 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
